test_fifo_top: RTL and testbench

TEST_FIFO_TOP -- requirements
Module: test_fifo

---
 rtl/test_fifo_top.sv | 160 ++++++++++++++++
 tb/tb_test_fifo_top.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/test_fifo_top.sv
`default_nettype none
// ============================================================================
// Module      : test_fifo_top
// Description : Four-entry, 3-bit FIFO driven by push/pop buttons. The wr and
//               rd levels are synchronized and optionally debounced. A single
//               one-cycle push/pop strobe is generated per press. Status,
//               last-event code and head data are shown on an 8-bit LED bus.
//               Optional feature macro: TEST_FIFO_DEBOUNCE_EN (debouncer on
//               the synchronized wr/rd levels).
// Revision    : 1.0 - initial release
// ============================================================================
module test_fifo_top #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] sw,
  output logic [7:0] led,
  output logic [1:0] w_ptr_reg,
  output logic [1:0] r_ptr_reg,
  output logic       push,
  output logic       pop
);

  // Refuse a debounce length that can never settle.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Bit 0 carries wr, bit 1 carries rd through the input conditioning.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_lvl;
  logic [1:0] r_prev;
  logic [1:0] w_rise;

  // Two-flop synchronizer. Preset to 1 on reset so a button still held
  // across reset is never mistaken for a fresh low-to-high transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {rd, wr};
      r_sync2 <= r_sync1;
    end
  end

`ifdef TEST_FIFO_DEBOUNCE_EN
  localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_db;
  logic [c_CW-1:0] r_dcnt [2];

  // Debouncer: the accepted level follows the input only after it has
  // differed for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db      <= 2'b11;
      r_dcnt[0] <= '0;
      r_dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dcnt[i] == c_LAST) begin
            r_db[i]   <= r_sync2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 1'b1;
          end
        end else begin
          r_dcnt[i] <= '0;
        end
      end
    end
  end

  assign w_lvl = r_db;
`else
  assign w_lvl = r_sync2;
`endif

  // Previous conditioned level, for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= 2'b11;
    else        r_prev <= w_lvl;
  end

  assign w_rise = w_lvl & ~r_prev;
  assign push   = w_rise[0];
  assign pop    = w_rise[1];

  // FIFO state
  logic [2:0] r_mem [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_cnt;
  logic       r_error;
  logic [1:0] r_fruta;

  logic w_full, w_empty, w_push_ok, w_pop_ok, w_rej;
  logic [2:0] w_salida;

  assign w_full    = (r_cnt == 3'd4);
  assign w_empty   = (r_cnt == 3'd0);
  // A pop frees the head slot in the same cycle, so push is allowed when full
  // only alongside an accepted pop (which requires non-empty).
  assign w_pop_ok  = pop  & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pop_ok);
  assign w_rej     = (push & ~w_push_ok) | (pop & ~w_pop_ok);
  assign w_salida  = w_empty ? 3'b000 : r_mem[r_rptr];

  // Storage, pointers and occupancy update on accepted operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 3'b000;
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_cnt  <= 3'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= sw;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 2'd1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Error flag and last-event code. A cycle with both operations accepted
  // reports push, the write being the newer data in the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
      r_fruta <= 2'b00;
    end else if (w_rej) begin
      r_error <= 1'b1;
      r_fruta <= 2'b11;
    end else if (w_push_ok) begin
      r_error <= 1'b0;
      r_fruta <= 2'b01;
    end else if (w_pop_ok) begin
      r_error <= 1'b0;
      r_fruta <= 2'b10;
    end
  end

  assign led       = {w_full, w_empty, r_error, r_fruta, w_salida};
  assign w_ptr_reg = r_wptr;
  assign r_ptr_reg = r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_test_fifo_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_fifo_top
// Description : Directed self-checking bench for test_fifo_top (debounce off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_fifo_top;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [2:0] sw = 3'b000;
  logic [7:0] led;
  logic [1:0] w_ptr_reg, r_ptr_reg;
  logic       push, pop;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_pop  = 0;
  int p0, q0;

  test_fifo_top #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .sw(sw),
    .led(led), .w_ptr_reg(w_ptr_reg), .r_ptr_reg(r_ptr_reg),
    .push(push), .pop(pop)
  );

  always #5 clk = ~clk;

  // Strobe counters; a one-cycle pulse spans exactly one falling edge.
  always @(negedge clk) begin
    if (push) n_push++;
    if (pop)  n_pop++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One button press: held 45 cycles, released 45 cycles.
  task automatic press(input logic dw, input logic dr, input logic [2:0] d);
    @(negedge clk);
    sw = d; wr = dw; rd = dr;
    repeat (45) @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    repeat (45) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led",  led,       8'b0100_0000);
    chk("rst_wptr", w_ptr_reg, 2'd0);
    chk("rst_rptr", r_ptr_reg, 2'd0);
    chk("rst_push", push,      1'b0);
    chk("rst_pop",  pop,       1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // First press with latency check: sampled at edge k, push k+1..k+2
    @(negedge clk);
    sw = 3'd0; wr = 1'b1;
    @(posedge clk);                 // edge k
    #1 chk("lat_push_k", push, 1'b0);
    @(posedge clk);                 // edge k+1
    #1 chk("lat_push_k1", push, 1'b1);
    @(posedge clk);                 // edge k+2 commits
    #1 chk("lat_push_k2", push, 1'b0);
    chk("lat_wptr", w_ptr_reg, 2'd1);
    repeat (45) @(negedge clk);
    wr = 1'b0;
    repeat (45) @(negedge clk);
    chk("press0_pushes", n_push, 1);

    // Fill with 1,2,3
    for (int i = 1; i < 4; i++) begin
      p0 = n_push;
      press(1'b1, 1'b0, 3'(i));
      chk("fill_one_push", n_push - p0, 1);
    end
    chk("full_led",  led,       8'b1000_1000);
    chk("full_wptr", w_ptr_reg, 2'd0);
    chk("full_rptr", r_ptr_reg, 2'd0);

    // Pop, refill, pop
    q0 = n_pop;
    press(1'b0, 1'b1, 3'd0);
    chk("pop1_pulses", n_pop - q0, 1);
    chk("pop1_led",  led,       8'b0001_0001);
    chk("pop1_rptr", r_ptr_reg, 2'd1);
    press(1'b1, 1'b0, 3'd2);
    chk("refill_led",  led,       8'b1000_1001);
    chk("refill_wptr", w_ptr_reg, 2'd1);
    press(1'b0, 1'b1, 3'd0);
    chk("pop2_led",  led,       8'b0001_0010);
    chk("pop2_rptr", r_ptr_reg, 2'd2);

    // Refill to full, then push while full is rejected
    press(1'b1, 1'b0, 3'd5);
    chk("full2_led", led, 8'b1000_1010);
    press(1'b1, 1'b0, 3'd7);
    chk("ovf_led",  led,       8'b1011_1010);
    chk("ovf_wptr", w_ptr_reg, 2'd2);
    chk("ovf_rptr", r_ptr_reg, 2'd2);
    press(1'b0, 1'b1, 3'd0);
    chk("ovf_clr_led",  led,       8'b0001_0011);
    chk("ovf_clr_rptr", r_ptr_reg, 2'd3);

    // Simultaneous push and pop on a full FIFO
    press(1'b1, 1'b0, 3'd6);
    chk("full3_led", led, 8'b1000_1011);
    p0 = n_push; q0 = n_pop;
    press(1'b1, 1'b1, 3'd4);
    chk("sim_push_n", n_push - p0, 1);
    chk("sim_pop_n",  n_pop - q0,  1);
    chk("sim_flags",  led[7:5],    3'b100);
    chk("sim_salida", led[2:0],    3'd2);
    chk("sim_wptr",   w_ptr_reg,   2'd0);
    chk("sim_rptr",   r_ptr_reg,   2'd0);

    // Pop on empty after reset
    do_reset();
    chk("rst2_led", led, 8'b0100_0000);
    press(1'b0, 1'b1, 3'd0);
    chk("unf_led",  led,       8'b0111_1000);
    chk("unf_rptr", r_ptr_reg, 2'd0);

    // Simultaneous push and pop while empty: push wins, pop rejected
    press(1'b1, 1'b1, 3'd5);
    chk("sim_empty_led",  led,       8'b0011_1101);
    chk("sim_empty_wptr", w_ptr_reg, 2'd1);
    chk("sim_empty_rptr", r_ptr_reg, 2'd0);

    // Reset asserted mid-press with entries stored
    do_reset();
    press(1'b1, 1'b0, 3'd1);
    press(1'b1, 1'b0, 3'd2);
    chk("pre_mid_wptr", w_ptr_reg, 2'd2);
    @(negedge clk);
    sw = 3'd3; wr = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_led",  led,       8'b0100_0000);
    chk("mid_rst_wptr", w_ptr_reg, 2'd0);
    chk("mid_rst_rptr", r_ptr_reg, 2'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    p0 = n_push;
    repeat (20) @(negedge clk);
    chk("held_no_push", n_push - p0, 0);
    chk("held_wptr",    w_ptr_reg,   2'd0);
    wr = 1'b0;
    repeat (10) @(negedge clk);
    press(1'b1, 1'b0, 3'd3);
    chk("repress_push", n_push - p0, 1);
    chk("repress_led",  led, 8'b0000_1011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
